// File: rtl/hazard_scheduler.sv
// Scoreboard issue controller: tracks outstanding register/flag writes, stalls issue on
// RAW hazards, saturated counters or a busy bus, and times the post-jump flush window.
module hazard_scheduler #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_dest_write,
  input  logic [3:0]  issue_dest_index,
  input  logic        issue_src_a_used,
  input  logic        issue_src_b_used,
  input  logic [3:0]  issue_src_a_index,
  input  logic [3:0]  issue_src_b_index,
  input  logic        issue_writes_status,
  input  logic        issue_reads_status,
  input  logic        bus_busy,
  input  logic        retire_write,
  input  logic [3:0]  retire_index,
  input  logic        retire_status,
  input  logic        jump,
  input  logic        cancel_valid,
  input  logic [3:0]  cancel_index,
  input  logic        cancel_status,
  output logic        stall,
  output logic        issue_accept,
  output logic        flush,
  output logic [15:0] pending,
  output logic        status_pending,
  output logic        idle,
  output logic        scoreboard_error
);

  typedef enum logic {IDLE, FLUSHING} flush_state_t;

  localparam logic [1:0] MAX_CNT   = 2'(MAX_INFLIGHT);
  localparam logic [3:0] FLUSH_LEN = 4'(FLUSH_CYCLES);

  logic [1:0]   cnt_q [16];
  logic [1:0]   cnt_d [16];
  logic [1:0]   scnt_q, scnt_d;
  logic [3:0]   fcnt_q, fcnt_d;
  flush_state_t state_q, state_d;
  logic         err_q, err_d;
  logic         hazard;

  // Returns {error, next_count}; clamps the net result into the 2-bit range.
  function automatic logic [2:0] count_update(input logic [1:0] c, input logic inc,
                                              input logic dec_r, input logic dec_c);
    logic signed [3:0] net;
    net = $signed({2'b00, c}) + $signed({3'b000, inc})
        - $signed({3'b000, dec_r}) - $signed({3'b000, dec_c});
    if (net < 4'sd0) return {1'b1, 2'd0};
    if (net > 4'sd3) return {1'b1, 2'd3};
    return {1'b0, net[1:0]};
  endfunction

  always_comb begin
    for (int n = 0; n < 16; n++) pending[n] = (cnt_q[n] != 2'd0);
  end

  assign status_pending   = (scnt_q != 2'd0);
  assign idle             = ~|pending & ~status_pending;
  assign flush            = (fcnt_q != 4'd0);
  assign scoreboard_error = err_q;

  assign hazard = (issue_src_a_used & pending[issue_src_a_index])
                | (issue_src_b_used & pending[issue_src_b_index])
                | (issue_reads_status & status_pending);

  assign stall = issue_valid & (hazard | bus_busy | flush
                 | (issue_dest_write & (cnt_q[issue_dest_index] == MAX_CNT))
                 | (issue_writes_status & (scnt_q == MAX_CNT)));

  assign issue_accept = issue_valid & ~stall;

  always_comb begin
    logic [2:0] upd;
    upd   = '0;
    err_d = err_q;
    for (int n = 0; n < 16; n++) begin
      upd = count_update(cnt_q[n],
                         issue_accept & issue_dest_write & (issue_dest_index == 4'(n)),
                         retire_write & (retire_index == 4'(n)),
                         cancel_valid & (cancel_index == 4'(n)));
      cnt_d[n] = upd[1:0];
      err_d    = err_d | upd[2];
    end
    upd    = count_update(scnt_q, issue_accept & issue_writes_status, retire_status, cancel_status);
    scnt_d = upd[1:0];
    err_d  = err_d | upd[2];
  end

  // Flush window: jump (re)loads the full length in either state.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (jump) begin
          fcnt_d  = FLUSH_LEN;
          state_d = FLUSHING;
        end
      end
      FLUSHING: begin
        if (jump) fcnt_d = FLUSH_LEN;
        else      fcnt_d = fcnt_q - 4'd1;
        state_d = (fcnt_d != 4'd0) ? FLUSHING : IDLE;
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 16; n++) cnt_q[n] <= 2'd0;
      scnt_q  <= 2'd0;
      fcnt_q  <= 4'd0;
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      for (int n = 0; n < 16; n++) cnt_q[n] <= cnt_d[n];
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Scoreboard-based issue controller for the MaxiCore32 pipeline. It tracks outstanding register-file and status-register writes between decode (issue) and the write-back strobes from the stage-2 register logic. It stalls issue on read-after-write hazards, a full scoreboard or a busy memory bus. It also generates a timed flush after a taken jump.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush` is held after a taken jump (1..15).
- MAX_INFLIGHT, 3: outstanding writes allowed per register (1..3; counters are 2 bits).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_dest_write  in  1  instruction writes a register.
- issue_dest_index  in  4  destination register.
- issue_src_a_used, issue_src_b_used  in  1 each  source operand in use.
- issue_src_a_index, issue_src_b_index  in  4 each  source registers.
- issue_writes_status  in  1  ALU-class instruction; updates flags.
- issue_reads_status  in  1  conditional branch/jump; reads flags.
- bus_busy  in  1  memory interface cannot accept a new cycle.
- retire_write  in  1  stage-2 `write` strobe.
- retire_index  in  4  stage-2 `write_index`.
- retire_status  in  1  stage-2 `status_register_write`.
- jump  in  1  stage-2 taken branch/jump.
- cancel_valid  in  1  squashed instruction had been accepted with a destination.
- cancel_index  in  4  its destination.
- cancel_status  in  1  the squashed instruction had set status pending.
- stall  out  1  combinational; issue must hold.
- issue_accept  out  1  combinational; equals `issue_valid & ~stall`.
- flush  out  1  registered; kill fetch/decode contents.
- pending  out  16  bit n set when counter n is nonzero.
- status_pending  out  1  flags write outstanding.
- idle  out  1  all counters zero and status not pending.
- scoreboard_error  out  1  sticky underflow/overflow flag.

## Operation
- State:
  - sixteen 2-bit counters `cnt[n]`;
  - a 2-bit status counter `scnt`;
  - a 4-bit flush down-counter `fcnt`;
  - the `scoreboard_error` bit.
- Hazard term, combinational:
  - `src_a_used & pending[src_a_index]`;
  - or `src_b_used & pending[src_b_index]`;
  - or `issue_reads_status & status_pending`.
- `stall` = `issue_valid & (hazard | bus_busy | flush | (issue_dest_write & cnt[dest] == MAX_INFLIGHT) | (issue_writes_status & scnt == MAX_INFLIGHT))`.
  - `stall` is 0 whenever `issue_valid` is 0.
- Counter update, per register n, each clock:
  - `cnt[n] <= cnt[n] + inc - dec_r - dec_c`;
  - `inc` = `issue_accept & issue_dest_write & dest == n`;
  - `dec_r` = `retire_write & retire_index == n`;
  - `dec_c` = `cancel_valid & cancel_index == n`.
- The status counter updates the same way, using `issue_writes_status`, `retire_status` and `cancel_status`.
- Width rules:
  - Net results below 0 clamp to 0 and set `scoreboard_error`.
  - Net results above 3 cannot occur, because a saturated counter stalls issue.
  - If an increment would exceed 3 anyway, the counter holds at 3 and `scoreboard_error` is set.
- Simultaneous issue and retire on the same index leave the counter unchanged.
- Retire and cancel on the same index give a net change of -2.
- Flush state machine, states IDLE and FLUSHING (`fcnt != 0`):
  - `jump` in either state loads `fcnt <= FLUSH_CYCLES`.
  - In FLUSHING without `jump`, `fcnt` decrements.
  - `flush = (fcnt != 0)`.
- Retire and cancel are processed during a flush. Issue is blocked during a flush.
- `scoreboard_error` clears only on reset.

## Timing
- Reset (`reset` low, asynchronous) forces:
  - all counters 0 and `fcnt` 0;
  - `flush` 0, `pending` 0, `status_pending` 0;
  - `idle` 1, `scoreboard_error` 0.
- `stall` and `issue_accept` follow their combinational inputs in the reset state.
- Reset is released synchronously to `clock`.
- `pending`, `status_pending` and `idle` are decoded from registered counters, so they change one cycle after the causing edge.
- A write accepted in cycle t shows in `pending` at t+1.
- A retire in cycle t clears `pending` at t+1.
- There is no same-cycle retire-to-issue bypass: a dependent instruction waiting on a retire in cycle t issues at t+1 at the earliest.
- `jump` sampled at edge t gives `flush` high from t+1 through t+FLUSH_CYCLES inclusive.
- `jump` during a flush restarts the full window.
- Reset asserted mid-flush drops `flush` immediately.
- `bus_busy` affects only `stall`; it changes no state.

## Test plan
- Reset, then issue with `dest_index=5`, then a dependent `src_a_index=5`:
  - `pending[5]` goes to 1 one cycle after the accept;
  - dependent `stall=1` until `retire_write/retire_index=5`;
  - dependent `issue_accept=1` the cycle after the retire.
- Three accepted writes to r3 with no retire:
  - `cnt[3]=3`;
  - a fourth write to r3 gives `stall=1`;
  - one retire, then the fourth is accepted next cycle.
- Issue to r7 and retire r7 in the same cycle with `cnt[7]=1`: `cnt[7]` stays 1 and `pending[7]=1`.
- Pulse `jump` at cycle 10 with FLUSH_CYCLES=2:
  - `flush` high in cycles 11–12;
  - a second `jump` at 11 extends `flush` through 13;
  - `issue_valid` during the flush gives `stall=1`.
- ALU issue with `issue_writes_status=1`, then `issue_reads_status=1`:
  - the reader stalls until `retire_status`;
  - `cancel_status` on a second outstanding writer returns `status_pending` to 0 and `idle` to 1.
- `retire_write` to r9 with `cnt[9]=0`:
  - `cnt[9]` stays 0 and `scoreboard_error` is set to 1 and stays set;
  - asynchronous reset low mid-cycle clears it immediately.
